arcade_input_map: RTL and testbench
===================================

Name: arcade_input_map

Overview:
- Parametrised player-input front end for arcade cores.
- Merges PS/2 keyboard events and up to four HPS joysticks into per-player active-high control vectors.
- Applies a 4-way screen-rotation remap and generates fixed-width coin pulses.
- Sits between hps_io and the game core; the top level only inverts and packs its outputs into the core's input registers.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4).
- NUM_BUTTONS, 3, action buttons per player (1..4).
- COIN_PULSE_CYCLES, 600000, coin output width in clk_sys cycles (≥2).
- AUTOFIRE_PERIOD, 200000, autofire half-period in clk_sys cycles (≥2).

Ports:
- clk_sys  in  1  system clock.
- RESET_N  in  1  synchronous reset, active low.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = extended).
- joy  in  NUM_PLAYERS*16  joystick p at [16p+15:16p]. Bits: [0] right, [1] left, [2] down, [3] up, [4+:NUM_BUTTONS] buttons, [4+NUM_BUTTONS] start, [5+NUM_BUTTONS] coin.
- rot  in  2  0 none, 1 quarter (horizontal mode), 2 half, 3 three-quarter.
- coin_from_start  in  1  start press also generates a coin for that player.
- autofire_en  in  NUM_PLAYERS  per-player autofire request on button 0.
- dir  out  NUM_PLAYERS*4  per player {up,down,left,right}, active high.
- btn  out  NUM_PLAYERS*NUM_BUTTONS  action buttons, active high.
- start  out  NUM_PLAYERS  start, active high.
- coin  out  NUM_PLAYERS  coin pulse, active high.
- test  out  1  service/test key.

Behaviour:
- Reset (RESET_N=0 at an edge): all key latches, counters and outputs go to 0. The toggle tracker loads ps2_key[10], so a stale event is not replayed.
- Keyboard event: accepted at the edge where ps2_key[10] differs from the tracker. The matching key latch takes ps2_key[9]. Unknown codes are ignored.
- Key map, P1:
  - Arrows match on low 8 bits with bit 8 ignored: 75 up, 72 down, 6B left, 74 right.
  - 029 or 014 → btn0; 011 → btn1; 012 → btn2.
  - 005 or 016 → start0; 02E → coin0.
- Key map, P2 (if NUM_PLAYERS≥2):
  - 02D up, 02B down, 023 left, 034 right.
  - 01C → btn0; 01B → btn1; 015 → btn2.
  - 006 or 01E → start1; 036 → coin1.
- Key map, P3/P4: 026 / 025 → start2 / start3; 03D / 03E → coin2 / coin3. Their directions and buttons come from joysticks only.
- Test key: 02C → test.
- Merge: raw player signal = keyboard latch OR joystick bit.
- Rotation remap, applied to the merged raw directions before registering:
  - rot 1: up←left, down←right, left←down, right←up.
  - rot 2: up←down, down←up, left←right, right←left.
  - rot 3: up←right, down←left, left←up, right←down.
- Latency: dir, btn, start and test are registered. Joystick change → output after 1 cycle. Keyboard event → output after 2 cycles.
- Coin source per player: merged coin, OR merged start when coin_from_start=1.
- Coin pulse, per-player FSM:
  - IDLE: on a source rising edge (edge detector, 1 cycle), go to PULSE and load counter = COIN_PULSE_CYCLES-1.
  - PULSE: coin=1, counter decrements; at 0 go to WAITREL.
  - WAITREL: coin=0; go to IDLE once the source is 0.
  - Retriggers during PULSE or WAITREL are ignored. Counter width is $clog2(COIN_PULSE_CYCLES).
  - Simultaneous keyboard and joystick coin produce one pulse. Players are independent.
- rot changes mid-press take effect the next cycle. Held keys stay latched across the change.

Optional Feature:
- Macro ARCADE_INPUT_AUTOFIRE_EN.
- Defined: while autofire_en[p]=1 and button 0 is held, btn0 is 1 on the first output cycle. It then toggles every AUTOFIRE_PERIOD cycles from a per-player counter. On release, btn0=0 immediately and the counter resets.
- Undefined: autofire_en is ignored; btn0 follows the merged input. No counters are synthesised.

Decomposition:
- Package arcade_input_pkg:
  - scan-code localparams;
  - rotation enum (ROT_0, ROT_90, ROT_180, ROT_270);
  - coin FSM state typedef (IDLE, PULSE, WAITREL);
  - joystick bit-index function of NUM_BUTTONS.
- One sub-module, arcade_coin_pulse: per-player edge detect, FSM and counter, instantiated NUM_PLAYERS times via generate.

Test Plan:
- Reset: hold RESET_N=0 with joy all ones. → All outputs 0. After release with ps2_key[10] unchanged → no key event.
- Keyboard P1 up: ps2_key toggle with {1,0x175}. → dir[P1] up=1 after 2 cycles. Release event {0,0x075} → up=0. Repeat with rot=1 → right=1 instead.
- Joystick P2 rot=2, joy bit1 (left) set. → P2 right=1 after 1 cycle. Left, up and down stay 0.
- Coin with COIN_PULSE_CYCLES=8, key 02E held 20 cycles. → coin0 high exactly 8 cycles, then low. Second press while still held → no pulse. Release then press → new 8-cycle pulse.
- coin_from_start=1, joystick P1 start and key 02E pressed the same cycle. → Single 8-cycle coin0 pulse; start0=1 for the hold duration.
- Autofire with ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_PERIOD=4, autofire_en=1, space held 20 cycles. → btn0 pattern 1111 0000 1111…. Release → 0 next cycle. Without the macro → btn0 steady 1.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: shared scan codes, key classes, rotation and coin FSM
// types, plus small helpers used by the arcade input front end.
package arcade_input_pkg;

  // Arrow keys match on the low byte only so both the plain and the
  // extended (E0-prefixed) variants drive the P1 directions.
  localparam logic [7:0] KEY_ARROW_UP    = 8'h75;
  localparam logic [7:0] KEY_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_ARROW_RIGHT = 8'h74;

  // Full 9-bit codes (bit 8 = extended)
  localparam logic [8:0] KEY_P1_BTN0_A  = 9'h029;
  localparam logic [8:0] KEY_P1_BTN0_B  = 9'h014;
  localparam logic [8:0] KEY_P1_BTN1    = 9'h011;
  localparam logic [8:0] KEY_P1_BTN2    = 9'h012;
  localparam logic [8:0] KEY_P1_START_A = 9'h005;
  localparam logic [8:0] KEY_P1_START_B = 9'h016;
  localparam logic [8:0] KEY_P1_COIN    = 9'h02E;

  localparam logic [8:0] KEY_P2_UP      = 9'h02D;
  localparam logic [8:0] KEY_P2_DOWN    = 9'h02B;
  localparam logic [8:0] KEY_P2_LEFT    = 9'h023;
  localparam logic [8:0] KEY_P2_RIGHT   = 9'h034;
  localparam logic [8:0] KEY_P2_BTN0    = 9'h01C;
  localparam logic [8:0] KEY_P2_BTN1    = 9'h01B;
  localparam logic [8:0] KEY_P2_BTN2    = 9'h015;
  localparam logic [8:0] KEY_P2_START_A = 9'h006;
  localparam logic [8:0] KEY_P2_START_B = 9'h01E;
  localparam logic [8:0] KEY_P2_COIN    = 9'h036;

  localparam logic [8:0] KEY_P3_START   = 9'h026;
  localparam logic [8:0] KEY_P4_START   = 9'h025;
  localparam logic [8:0] KEY_P3_COIN    = 9'h03D;
  localparam logic [8:0] KEY_P4_COIN    = 9'h03E;

  localparam logic [8:0] KEY_TEST       = 9'h02C;

  // Key classes. Direction classes equal the joystick bit positions
  // (0 right, 1 left, 2 down, 3 up) and buttons follow from 4 upward,
  // so a decoded class indexes the latch vectors directly.
  localparam logic [3:0] KIND_RIGHT = 4'd0;
  localparam logic [3:0] KIND_LEFT  = 4'd1;
  localparam logic [3:0] KIND_DOWN  = 4'd2;
  localparam logic [3:0] KIND_UP    = 4'd3;
  localparam logic [3:0] KIND_BTN0  = 4'd4;
  localparam logic [3:0] KIND_BTN1  = 4'd5;
  localparam logic [3:0] KIND_BTN2  = 4'd6;
  localparam logic [3:0] KIND_START = 4'd8;
  localparam logic [3:0] KIND_COIN  = 4'd9;
  localparam logic [3:0] KIND_TEST  = 4'd10;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    WAITREL = 2'd2
  } coinState_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] player;
    logic [3:0] kind;
  } keyDecode_t;

  // Joystick word layout depends on how many action buttons precede
  // the start and coin bits.
  function automatic int joyStartBit(input int numButtons);
    return 4 + numButtons;
  endfunction

  function automatic int joyCoinBit(input int numButtons);
    return 5 + numButtons;
  endfunction

  // Classify a scan code into (player, key class); unknown codes come
  // back with valid=0.
  function automatic keyDecode_t decodeKey(input logic [8:0] code);
    keyDecode_t d;
    d.valid  = 1'b1;
    d.player = 2'd0;
    d.kind   = KIND_UP;
    case (code[7:0])
      KEY_ARROW_UP:    d.kind = KIND_UP;
      KEY_ARROW_DOWN:  d.kind = KIND_DOWN;
      KEY_ARROW_LEFT:  d.kind = KIND_LEFT;
      KEY_ARROW_RIGHT: d.kind = KIND_RIGHT;
      default: begin
        case (code)
          KEY_P1_BTN0_A, KEY_P1_BTN0_B:   d.kind = KIND_BTN0;
          KEY_P1_BTN1:                    d.kind = KIND_BTN1;
          KEY_P1_BTN2:                    d.kind = KIND_BTN2;
          KEY_P1_START_A, KEY_P1_START_B: d.kind = KIND_START;
          KEY_P1_COIN:                    d.kind = KIND_COIN;
          KEY_TEST:                       d.kind = KIND_TEST;
          KEY_P2_UP:    begin d.player = 2'd1; d.kind = KIND_UP;    end
          KEY_P2_DOWN:  begin d.player = 2'd1; d.kind = KIND_DOWN;  end
          KEY_P2_LEFT:  begin d.player = 2'd1; d.kind = KIND_LEFT;  end
          KEY_P2_RIGHT: begin d.player = 2'd1; d.kind = KIND_RIGHT; end
          KEY_P2_BTN0:  begin d.player = 2'd1; d.kind = KIND_BTN0;  end
          KEY_P2_BTN1:  begin d.player = 2'd1; d.kind = KIND_BTN1;  end
          KEY_P2_BTN2:  begin d.player = 2'd1; d.kind = KIND_BTN2;  end
          KEY_P2_START_A, KEY_P2_START_B: begin
            d.player = 2'd1;
            d.kind   = KIND_START;
          end
          KEY_P2_COIN:  begin d.player = 2'd1; d.kind = KIND_COIN;  end
          KEY_P3_START: begin d.player = 2'd2; d.kind = KIND_START; end
          KEY_P4_START: begin d.player = 2'd3; d.kind = KIND_START; end
          KEY_P3_COIN:  begin d.player = 2'd2; d.kind = KIND_COIN;  end
          KEY_P4_COIN:  begin d.player = 2'd3; d.kind = KIND_COIN;  end
          default:      d.valid = 1'b0;
        endcase
      end
    endcase
    return d;
  endfunction

  // Remap {up,down,left,right} for a rotated cabinet.
  function automatic logic [3:0] rotateDir(input rot_t r, input logic [3:0] d);
    logic [3:0] res;
    case (r)
      ROT_90:  res = {d[1], d[0], d[2], d[3]};
      ROT_180: res = {d[2], d[3], d[0], d[1]};
      ROT_270: res = {d[0], d[1], d[3], d[2]};
      default: res = d;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// arcade_coin_pulse: turns a level coin source into exactly one
// COIN_PULSE_CYCLES-wide pulse per press; the source must drop before
// another pulse can start.
module arcade_coin_pulse
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 600000
) (
  input  logic clk_sys,
  input  logic RESET_N,
  input  logic i_src,
  output logic o_coin
);

  localparam int CNT_W = $clog2(COIN_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_PULSE_CYCLES - 1);

  coinState_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_srcPrev;
  logic             r_coin;
  logic             w_rise;

  assign w_rise = i_src & ~r_srcPrev;

  // Edge detect, pulse timing and release wait in one registered FSM
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_srcPrev <= 1'b0;
      r_coin    <= 1'b0;
    end else begin
      r_srcPrev <= i_src;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PULSE;
            r_count <= CNT_LOAD;
            r_coin  <= 1'b1;
          end
        end
        PULSE: begin
          if (r_count == '0) begin
            r_state <= WAITREL;
            r_coin  <= 1'b0;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        WAITREL: begin
          if (!i_src) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_coin  <= 1'b0;
        end
      endcase
    end
  end

  assign o_coin = r_coin;

endmodule

// File: rtl/arcade_input_map.sv
// arcade_input_map: merges PS/2 keyboard events and HPS joysticks into
// per-player active-high controls, applies screen rotation and produces
// coin pulses. Optional button-0 autofire is built when the macro
// ARCADE_INPUT_AUTOFIRE_EN is defined; otherwise autofire_en is ignored.
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int NUM_BUTTONS       = 3,
  parameter int COIN_PULSE_CYCLES = 600000,
  parameter int AUTOFIRE_PERIOD   = 200000
) (
  input  logic                             clk_sys,
  input  logic                             RESET_N,
  input  logic [10:0]                      ps2_key,
  input  logic [NUM_PLAYERS*16-1:0]        joy,
  input  logic [1:0]                       rot,
  input  logic                             coin_from_start,
  input  logic [NUM_PLAYERS-1:0]           autofire_en,
  output logic [NUM_PLAYERS*4-1:0]         dir,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn,
  output logic [NUM_PLAYERS-1:0]           start,
  output logic [NUM_PLAYERS-1:0]           coin,
  output logic                             test
);

  localparam int JOY_START = joyStartBit(NUM_BUTTONS);
  localparam int JOY_COIN  = joyCoinBit(NUM_BUTTONS);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AF_W = $clog2(AUTOFIRE_PERIOD);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_PERIOD - 1);
`else
  logic w_unused_autofire;
  assign w_unused_autofire = ^{autofire_en, 32'(AUTOFIRE_PERIOD)};
`endif

  logic                                 r_toggle;
  logic                                 r_kbTest;
  logic                                 w_event;
  keyDecode_t                           w_key;
  rot_t                                 w_rot;

  logic [NUM_PLAYERS*4-1:0]             w_dirMerged;
  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]   w_btnMerged;
  logic [NUM_PLAYERS-1:0]               w_startMerged;
  logic [NUM_PLAYERS-1:0]               w_coinSrc;

  logic [NUM_PLAYERS*4-1:0]             r_dir;
  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]   r_btn;
  logic [NUM_PLAYERS-1:0]               r_start;
  logic                                 r_test;

  assign w_event = (ps2_key[10] != r_toggle);
  assign w_key   = decodeKey(ps2_key[8:0]);
  assign w_rot   = rot_t'(rot);

  // Track the PS/2 toggle and latch the service key; reloading the
  // tracker in reset keeps a stale event from replaying afterwards
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      r_toggle <= ps2_key[10];
      r_kbTest <= 1'b0;
    end else begin
      r_toggle <= ps2_key[10];
      if (w_event && w_key.valid && (w_key.kind == KIND_TEST)) begin
        r_kbTest <= ps2_key[9];
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]             r_kbDir;
    logic [NUM_BUTTONS-1:0] r_kbBtn;
    logic                   r_kbStart;
    logic                   r_kbCoin;
    logic                   w_hit;
    logic [3:0]             w_rawDir;
    logic [NUM_BUTTONS-1:0] w_rawBtn;
    logic [NUM_BUTTONS-1:0] w_btnOut;
    logic                   w_rawCoin;
    logic [9-NUM_BUTTONS:0] w_unused_joyHi;

    assign w_hit = w_event & w_key.valid & (w_key.player == 2'(p));

    // Keyboard latches for this player follow the pressed flag of each
    // accepted event that maps to them
    always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
        r_kbDir   <= '0;
        r_kbBtn   <= '0;
        r_kbStart <= 1'b0;
        r_kbCoin  <= 1'b0;
      end else if (w_hit) begin
        for (int d = 0; d < 4; d++) begin
          if (w_key.kind == 4'(d)) begin
            r_kbDir[d] <= ps2_key[9];
          end
        end
        for (int b = 0; b < NUM_BUTTONS; b++) begin
          if (w_key.kind == 4'(KIND_BTN0 + 4'(b))) begin
            r_kbBtn[b] <= ps2_key[9];
          end
        end
        if (w_key.kind == KIND_START) begin
          r_kbStart <= ps2_key[9];
        end
        if (w_key.kind == KIND_COIN) begin
          r_kbCoin <= ps2_key[9];
        end
      end
    end

    assign w_rawDir   = r_kbDir | joy[16*p +: 4];
    assign w_rawBtn   = r_kbBtn | joy[16*p+4 +: NUM_BUTTONS];
    assign w_rawCoin  = r_kbCoin | joy[16*p+JOY_COIN];
    assign w_unused_joyHi = joy[16*p+JOY_COIN+1 +: 10-NUM_BUTTONS];

    assign w_dirMerged[4*p +: 4]   = rotateDir(w_rot, w_rawDir);
    assign w_startMerged[p]        = r_kbStart | joy[16*p+JOY_START];
    assign w_coinSrc[p]            = w_rawCoin | (coin_from_start & w_startMerged[p]);
    assign w_btnMerged[NUM_BUTTONS*p +: NUM_BUTTONS] = w_btnOut;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [AF_W-1:0] r_afCnt;
    logic            r_afOff;
    logic            w_afActive;

    assign w_afActive = autofire_en[p] & w_rawBtn[0];

    // Autofire phase: held-on for the first period, then flips every
    // AUTOFIRE_PERIOD cycles; restarts whenever the button or enable drops
    always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
        r_afCnt <= '0;
        r_afOff <= 1'b0;
      end else if (!w_afActive) begin
        r_afCnt <= '0;
        r_afOff <= 1'b0;
      end else if (r_afCnt == AF_LAST) begin
        r_afCnt <= '0;
        r_afOff <= ~r_afOff;
      end else begin
        r_afCnt <= r_afCnt + 1'b1;
      end
    end

    // Gate button 0 with the autofire phase while autofire is requested
    always_comb begin
      w_btnOut    = w_rawBtn;
      w_btnOut[0] = w_rawBtn[0] & ~(autofire_en[p] & r_afOff);
    end
`else
    assign w_btnOut = w_rawBtn;
`endif

    arcade_coin_pulse #(
      .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
    ) u_coin (
      .clk_sys(clk_sys),
      .RESET_N(RESET_N),
      .i_src  (w_coinSrc[p]),
      .o_coin (coin[p])
    );
  end

  // Register the merged controls so the core sees glitch-free levels
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      r_dir   <= '0;
      r_btn   <= '0;
      r_start <= '0;
      r_test  <= 1'b0;
    end else begin
      r_dir   <= w_dirMerged;
      r_btn   <= w_btnMerged;
      r_start <= w_startMerged;
      r_test  <= r_kbTest;
    end
  end

  assign dir   = r_dir;
  assign btn   = r_btn;
  assign start = r_start;
  assign test  = r_test;

endmodule

// File: tb/tb_arcade_input_map.sv
// tb_arcade_input_map: directed stimulus with a queue-based scoreboard;
// a monitor compares every output after each clock edge against the
// expectations due in that cycle.
module tb_arcade_input_map;

  localparam int NP  = 2;
  localparam int NB  = 3;
  localparam int CPC = 8;
  localparam int AFP = 4;

  logic              clk_sys = 1'b0;
  logic              RESET_N;
  logic [10:0]       ps2_key;
  logic [NP*16-1:0]  joy;
  logic [1:0]        rot;
  logic              coin_from_start;
  logic [NP-1:0]     autofire_en;
  logic [NP*4-1:0]   dir;
  logic [NP*NB-1:0]  btn;
  logic [NP-1:0]     start;
  logic [NP-1:0]     coin;
  logic              test;

  arcade_input_map #(
    .NUM_PLAYERS(NP),
    .NUM_BUTTONS(NB),
    .COIN_PULSE_CYCLES(CPC),
    .AUTOFIRE_PERIOD(AFP)
  ) dut (
    .clk_sys(clk_sys),
    .RESET_N(RESET_N),
    .ps2_key(ps2_key),
    .joy(joy),
    .rot(rot),
    .coin_from_start(coin_from_start),
    .autofire_en(autofire_en),
    .dir(dir),
    .btn(btn),
    .start(start),
    .coin(coin),
    .test(test)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          due;
    string       name;
    logic [18:0] expVal;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int       cycleCount = 0;
  int       checkCount = 0;
  int       errorCount = 0;
  logic     togg;

  // Output word layout: {test, coin[1:0], start[1:0], btn[5:0], dir[7:0]}
  function automatic logic [18:0] packOut(input logic [7:0] d, input logic [5:0] b,
                                          input logic [1:0] s, input logic [1:0] c,
                                          input logic t);
    return {t, c, s, b, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic applyStimulus(input logic [NP*16-1:0] j, input logic [1:0] r);
    joy = j;
    rot = r;
  endtask

  task automatic kbEvent(input logic pressed, input logic [8:0] code);
    togg    = ~togg;
    ps2_key = {togg, pressed, code};
  endtask

  task automatic checkOutput(input string name, input int k, input logic [18:0] e);
    sbEntry_t ent;
    ent.due    = cycleCount + k;
    ent.name   = name;
    ent.expVal = e;
    sbQueue.push_back(ent);
  endtask

  // Monitor: after each rising edge, compare outputs against all due entries
  initial begin
    int          idx;
    logic [18:0] actual;
    forever begin
      @(posedge clk_sys);
      #1;
      cycleCount++;
      idx = 0;
      while (idx < sbQueue.size()) begin
        if (sbQueue[idx].due <= cycleCount) begin
          actual = {test, coin, start, btn, dir};
          checkCount++;
          if (sbQueue[idx].due != cycleCount || actual !== sbQueue[idx].expVal) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got %05h, expected %05h",
                     sbQueue[idx].name, cycleCount, actual, sbQueue[idx].expVal);
          end
          sbQueue.delete(idx);
        end else begin
          idx++;
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [NP*16-1:0] j;
    logic             afExp;

    RESET_N         = 1'b0;
    joy             = '1;
    rot             = 2'd0;
    coin_from_start = 1'b0;
    autofire_en     = '0;
    togg            = 1'b1;
    ps2_key         = {1'b1, 1'b1, 9'h175};

    tick(3);
    checkOutput("reset_zero", 1, '0);
    checkOutput("reset_zero_hold", 2, '0);
    tick(2);
    joy = '0;
    tick(1);
    RESET_N = 1'b1;
    for (int k = 1; k <= 3; k++) checkOutput("no_replay", k, '0);
    tick(4);

    // Keyboard P1 up, two-cycle latency, then release
    kbEvent(1'b1, 9'h175);
    checkOutput("kb_up_lat1", 1, '0);
    checkOutput("kb_up", 2, packOut(8'h08, 6'h0, 2'b00, 2'b00, 1'b0));
    checkOutput("kb_up_hold", 3, packOut(8'h08, 6'h0, 2'b00, 2'b00, 1'b0));
    tick(4);
    kbEvent(1'b0, 9'h075);
    checkOutput("kb_up_rel_lat1", 1, packOut(8'h08, 6'h0, 2'b00, 2'b00, 1'b0));
    checkOutput("kb_up_rel", 2, '0);
    tick(3);

    // Same key under quarter rotation, then rotation change while held
    rot = 2'd1;
    kbEvent(1'b1, 9'h175);
    checkOutput("kb_up_rot1", 2, packOut(8'h01, 6'h0, 2'b00, 2'b00, 1'b0));
    tick(3);
    rot = 2'd0;
    checkOutput("rot_change_held", 1, packOut(8'h08, 6'h0, 2'b00, 2'b00, 1'b0));
    tick(2);
    kbEvent(1'b0, 9'h075);
    checkOutput("rot_rel", 2, '0);
    tick(3);

    // Joystick: P2 left under half rotation plus P1 button 1
    j = '0;
    j[17] = 1'b1;
    j[5]  = 1'b1;
    applyStimulus(j, 2'd2);
    checkOutput("joy_p2_rot2", 1, packOut(8'h10, 6'b000010, 2'b00, 2'b00, 1'b0));
    tick(2);
    j = '0;
    j[3] = 1'b1;
    applyStimulus(j, 2'd3);
    checkOutput("joy_p1_rot3", 1, packOut(8'h02, 6'h0, 2'b00, 2'b00, 1'b0));
    tick(2);
    applyStimulus('0, 2'd0);
    checkOutput("joy_clear", 1, '0);
    tick(2);

    // Service key and P2 keyboard controls
    kbEvent(1'b1, 9'h02C);
    checkOutput("test_key", 2, packOut(8'h00, 6'h0, 2'b00, 2'b00, 1'b1));
    tick(3);
    kbEvent(1'b0, 9'h02C);
    checkOutput("test_rel", 2, '0);
    tick(3);
    kbEvent(1'b1, 9'h01B);
    checkOutput("kb_p2_btn1", 2, packOut(8'h00, 6'b010000, 2'b00, 2'b00, 1'b0));
    tick(3);
    kbEvent(1'b0, 9'h01B);
    checkOutput("kb_p2_btn1_rel", 2, '0);
    tick(3);
    kbEvent(1'b1, 9'h01E);
    checkOutput("kb_p2_start", 2, packOut(8'h00, 6'h0, 2'b10, 2'b00, 1'b0));
    tick(3);
    kbEvent(1'b0, 9'h01E);
    checkOutput("kb_p2_start_rel", 2, '0);
    tick(4);

    // Keyboard coin: one 8-cycle pulse, no retrigger while held
    kbEvent(1'b1, 9'h02E);
    for (int k = 1; k <= 12; k++)
      checkOutput("coin_pulse", k, packOut(8'h00, 6'h0, 2'b00,
                  (k >= 2 && k <= 9) ? 2'b01 : 2'b00, 1'b0));
    tick(12);
    kbEvent(1'b1, 9'h02E);
    for (int k = 1; k <= 10; k++) checkOutput("coin_no_retrigger", k, '0);
    tick(10);
    kbEvent(1'b0, 9'h02E);
    for (int k = 1; k <= 3; k++) checkOutput("coin_rel", k, '0);
    tick(3);
    kbEvent(1'b1, 9'h02E);
    for (int k = 1; k <= 12; k++)
      checkOutput("coin_second_pulse", k, packOut(8'h00, 6'h0, 2'b00,
                  (k >= 2 && k <= 9) ? 2'b01 : 2'b00, 1'b0));
    tick(12);
    kbEvent(1'b0, 9'h02E);
    tick(4);

    // Coin from start: joystick start and keyboard coin together
    coin_from_start = 1'b1;
    j = '0;
    j[7] = 1'b1;
    applyStimulus(j, 2'd0);
    kbEvent(1'b1, 9'h02E);
    for (int k = 1; k <= 14; k++)
      checkOutput("coin_from_start", k, packOut(8'h00, 6'h0, 2'b01,
                  (k <= 8) ? 2'b01 : 2'b00, 1'b0));
    tick(14);
    applyStimulus('0, 2'd0);
    kbEvent(1'b0, 9'h02E);
    checkOutput("cfs_rel", 1, '0);
    checkOutput("cfs_rel2", 2, '0);
    tick(4);
    coin_from_start = 1'b0;

    // P2 joystick coin: fixed width even after a short press
    j = '0;
    j[24] = 1'b1;
    applyStimulus(j, 2'd0);
    for (int k = 1; k <= 10; k++)
      checkOutput("coin_p2_joy", k, packOut(8'h00, 6'h0, 2'b00,
                  (k <= 8) ? 2'b10 : 2'b00, 1'b0));
    tick(3);
    applyStimulus('0, 2'd0);
    tick(9);

    // Space held with autofire requested on P1
    autofire_en = 2'b01;
    kbEvent(1'b1, 9'h029);
    for (int k = 1; k <= 20; k++) begin
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      afExp = (k >= 2) && ((((k - 2) / AFP) % 2) == 0);
`else
      afExp = (k >= 2);
`endif
      checkOutput("autofire_btn0", k, packOut(8'h00, {5'b0, afExp}, 2'b00, 2'b00, 1'b0));
    end
    tick(20);
    kbEvent(1'b0, 9'h029);
    checkOutput("autofire_last", 1, packOut(8'h00, 6'b000001, 2'b00, 2'b00, 1'b0));
    checkOutput("autofire_rel", 2, '0);
    tick(3);
    autofire_en = '0;

    // Drain outstanding expectations within a bounded window
    for (int w = 0; w < 40 && sbQueue.size() > 0; w++) tick(1);
    if (sbQueue.size() > 0) begin
      $display("[TB] FAIL drain: %0d expectations never compared, required 0",
               sbQueue.size());
      errorCount += sbQueue.size();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
